// File: rtl/cobra_seq_core.sv
// cobra_seq_core: multi-cycle instruction sequencer.
// Fetches 32-bit instructions over a req/ack port, executes them against a
// 32-entry register file (R0 hardwired to zero) and an external combinational
// ALU. Supports a blocking switch-input handshake and a HALT instruction.
// Optional feature macro: COBRA_RETIRE_CNT_EN adds retired_o, a free-running
// count of committed instructions (stalls and HALT are not counted).
module cobra_seq_core #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 10,
    parameter int OUT_REG = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [4:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic              alu_flag_i,
    input  logic [15:0]       in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_o,
    output logic              halted_o
`ifdef COBRA_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired_o
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];

    // Instruction fields, always decoded from the latched IR
    logic       f_b, f_c;
    logic [1:0] f_ws;
    logic [4:0] f_op, f_ra1, f_ra2, f_wa;
    logic [7:0] f_const;

    assign f_b     = ir_q[31];
    assign f_c     = ir_q[30];
    assign f_ws    = ir_q[29:28];
    assign f_op    = ir_q[27:23];
    assign f_ra1   = ir_q[22:18];
    assign f_ra2   = ir_q[17:13];
    assign f_const = ir_q[12:5];
    assign f_wa    = ir_q[4:0];

    logic [DATA_W-1:0] rd1, rd2, const_data, in_data_ext, wdata;
    logic [PC_W-1:0]   const_pc;
    logic              take;
    logic              commit;

    // R0 reads as zero regardless of storage contents
    assign rd1 = (f_ra1 == 5'd0) ? '0 : rf_q[f_ra1];
    assign rd2 = (f_ra2 == 5'd0) ? '0 : rf_q[f_ra2];

    assign const_data  = DATA_W'($signed(f_const));
    assign in_data_ext = DATA_W'($signed(in_data_i));
    assign const_pc    = PC_W'($signed(f_const));
    assign take        = f_b | (f_c & alu_flag_i);

    assign imem_addr_o = pc_q;
    assign alu_op_o    = f_op;
    assign alu_a_o     = rd1;
    assign alu_b_o     = rd2;
    assign out_o       = rf_q[OUT_REG];
    assign halted_o    = (state_q == S_HALT);

    // Write-back data select by write source
    always_comb begin
        wdata = alu_res_i;
        case (f_ws)
            2'b01:   wdata = const_data;
            2'b10:   wdata = in_data_ext;
            default: wdata = alu_res_i;
        endcase
    end

    // Next-state, fetch handshake, commit of RF write and PC update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        rf_d       = rf_q;
        imem_req_o = 1'b0;
        in_ready_o = 1'b0;
        commit     = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (f_b && f_c) begin
                    state_d = S_HALT;
                end else if (f_ws == 2'b10 && !in_valid_i) begin
                    state_d = S_EXEC;  // wait for the switch input
                end else begin
                    commit     = 1'b1;
                    in_ready_o = (f_ws == 2'b10);
                end
            end
            default: state_d = S_HALT;  // only reset leaves HALT
        endcase
        if (commit) begin
            if (f_ws != 2'b00 && f_wa != 5'd0)
                rf_d[f_wa] = wdata;
            pc_d    = take ? (pc_q + const_pc) : (pc_q + PC_W'(1));
            state_d = S_FETCH;
        end
    end

    // Architectural state registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            for (int i = 0; i < 32; i++)
                rf_q[i] <= rf_d[i];
        end
    end

`ifdef COBRA_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    assign retired_o = retired_q;

    // Count committed instructions, wrapping at 2^32
    always_comb begin
        retired_d = retired_q;
        if (commit)
            retired_d = retired_q + 32'd1;
    end

    // Retire counter register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            retired_q <= '0;
        else
            retired_q <= retired_d;
    end
`endif

endmodule

// File: tb/tb_cobra_seq_core.sv
// Bench for cobra_seq_core: ISA-level model checked every cycle plus directed
// programs with hand-computed expectations.
module tb_cobra_seq_core;

    localparam int DATA_W  = 32;
    localparam int PC_W    = 10;
    localparam int OUT_REG = 1;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              imem_req_o;
    logic [PC_W-1:0]   imem_addr_o;
    logic              imem_ack_i;
    logic [31:0]       imem_rdata_i;
    logic [4:0]        alu_op_o;
    logic [DATA_W-1:0] alu_a_o, alu_b_o, alu_res_i;
    logic              alu_flag_i;
    logic [15:0]       in_data_i = 16'h0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] out_o;
    logic              halted_o;
`ifdef COBRA_RETIRE_CNT_EN
    logic [31:0]       retired_o;
`endif

    cobra_seq_core #(.DATA_W(DATA_W), .PC_W(PC_W), .OUT_REG(OUT_REG)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_res_i(alu_res_i), .alu_flag_i(alu_flag_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_o(out_o), .halted_o(halted_o)
`ifdef COBRA_RETIRE_CNT_EN
        , .retired_o(retired_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // ---------------- environment: memory, ALU ----------------
    logic [31:0] imem [0:1023];
    bit          ack_always = 1'b1;
    int          ack_delay  = 0;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op == 5'd1) ? a - b : a + b;
    endfunction

    function automatic logic [31:0] mk(input logic b, input logic c, input logic [1:0] ws,
                                       input logic [4:0] op, input logic [4:0] ra1, input logic [4:0] ra2,
                                       input logic [7:0] cst, input logic [4:0] wa);
        return {b, c, ws, op, ra1, ra2, cst, wa};
    endfunction

    localparam logic [31:0] HALT_I = 32'hC000_0000;

    assign imem_rdata_i = imem[imem_addr_o];
    assign alu_res_i    = alu_f(alu_op_o, alu_a_o, alu_b_o);
    assign alu_flag_i   = alu_a_o[0];

    // Ack generator: either constant 1, or ack after ack_delay idle request cycles
    initial begin
        int wcnt;
        wcnt = 0;
        imem_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (ack_always) begin
                imem_ack_i = 1'b1;
            end else if (!imem_req_o) begin
                imem_ack_i = 1'b0;
                wcnt = 0;
            end else begin
                imem_ack_i = (wcnt == ack_delay);
                wcnt = imem_ack_i ? 0 : wcnt + 1;
            end
        end
    end

    // Posedges since reset release
    int cyc;
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ISA-level model: phases of one instruction's life, RF as a plain array
    int          m_ph;   // 0 boot, 1 fetching, 2 executing, 3 halted
    logic [9:0]  m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_rf [32];
    logic [31:0] m_ret;
    logic [9:0]  fq[$];  // observed fetch handshake addresses
    int          rq[$];  // cycles where in_ready_o was seen

    initial begin
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                chk("rst_req", imem_req_o, 0);
                chk("rst_addr", imem_addr_o, 0);
                chk("rst_out", out_o, 0);
                chk("rst_halted", halted_o, 0);
                chk("rst_alu_op", alu_op_o, 0);
                m_ph = 0; m_pc = '0; m_ir = '0; m_ret = '0;
                for (int i = 0; i < 32; i++) m_rf[i] = '0;
                fq.delete();
                rq.delete();
            end else begin
                logic b, c; logic [1:0] ws; logic [4:0] op, r1, r2, wa; logic [7:0] k;
                logic [31:0] v;
                logic taken;
                {b, c, ws, op, r1, r2, k, wa} = m_ir;
                chk("out_o", out_o, m_rf[OUT_REG]);
`ifdef COBRA_RETIRE_CNT_EN
                chk("retired_o", retired_o, m_ret);
`endif
                chk("imem_addr", imem_addr_o, m_pc);
                chk("alu_op", alu_op_o, op);
                chk("alu_a", alu_a_o, m_rf[r1]);
                chk("alu_b", alu_b_o, m_rf[r2]);
                chk("halted", halted_o, m_ph == 3);
                chk("imem_req", imem_req_o, m_ph == 1);
                chk("in_ready", in_ready_o, m_ph == 2 && !(b && c) && ws == 2'b10 && in_valid_i);
                if (imem_req_o && imem_ack_i) fq.push_back(imem_addr_o);
                if (in_ready_o) rq.push_back(cyc);
                case (m_ph)
                    0: m_ph = 1;
                    1: if (imem_ack_i) begin m_ir = imem[m_pc]; m_ph = 2; end
                    2: begin
                        if (b && c) m_ph = 3;
                        else if (!(ws == 2'b10 && !in_valid_i)) begin
                            v = (ws == 2'b01) ? {{24{k[7]}}, k} :
                                (ws == 2'b10) ? {{16{in_data_i[15]}}, in_data_i} :
                                                alu_f(op, m_rf[r1], m_rf[r2]);
                            if (ws != 2'b00 && wa != 5'd0) m_rf[wa] = v;
                            taken = b || (c && m_rf[r1][0]);
                            m_pc  = taken ? m_pc + {{2{k[7]}}, k} : m_pc + 10'd1;
                            m_ret = m_ret + 1;
                            m_ph  = 1;
                        end
                    end
                    default: m_ph = 3;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rst_on();
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = 16'h0;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    endtask

    task automatic rst_off(input bit ackall, input int dly);
        ack_always = ackall;
        ack_delay  = dly;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
    endtask

    task automatic wait_halt(input string name, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (halted_o) begin at = cyc; break; end
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL %s_timeout: halted_o never rose within 200 cycles", name);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int at;
        // T1: zero-wait fetch, load 5 into R1, halt
        rst_on();
        #1;
        chk("t1_rst_req", imem_req_o, 0);
        chk("t1_rst_halted", halted_o, 0);
        imem[0] = mk(0, 0, 2'b01, 0, 0, 0, 8'h05, 1);
        imem[1] = HALT_I;
        rst_off(1'b1, 0);
        wait_halt("t1", at);
        chk("t1_halt_cycle", at, 5);
        chk("t1_out", out_o, 32'd5);
        repeat (3) @(negedge clk_i);
        chk("t1_req_after_halt", imem_req_o, 0);
        chk("t1_halted", halted_o, 1);
        chk("t1_addr_frozen", imem_addr_o, 1);

        // T2: same program with 3 idle fetch cycles per instruction
        rst_on();
        imem[0] = mk(0, 0, 2'b01, 0, 0, 0, 8'h05, 1);
        imem[1] = HALT_I;
        rst_off(1'b0, 3);
        wait_halt("t2", at);
        chk("t2_halt_cycle", at, 11);
        chk("t2_out", out_o, 32'd5);

        // T3: input stall, then R1 = R2 + R0
        rst_on();
        imem[0] = mk(0, 0, 2'b10, 0, 0, 0, 8'h00, 2);
        imem[1] = mk(0, 0, 2'b11, 0, 2, 0, 8'h00, 1);
        imem[2] = HALT_I;
        rst_off(1'b1, 0);
        repeat (6) @(posedge clk_i);
        #1;
        in_valid_i = 1'b1;
        in_data_i  = 16'h8001;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        wait_halt("t3", at);
        chk("t3_ready_pulses", rq.size(), 1);
        if (rq.size() > 0) chk("t3_ready_cycle", rq[0], 6);
        chk("t3_out", out_o, 32'hFFFF_8001);

        // T4: conditional branch at PC=10, taken then not taken
        rst_on();
        imem[0]  = mk(0, 0, 2'b01, 0, 0, 0, 8'h01, 4);
        imem[1]  = mk(1, 0, 2'b00, 0, 0, 0, 8'h09, 0);
        imem[10] = mk(0, 1, 2'b00, 0, 4, 0, 8'hFD, 0);
        imem[7]  = mk(0, 0, 2'b01, 0, 0, 0, 8'h00, 4);
        imem[8]  = mk(1, 0, 2'b00, 0, 0, 0, 8'h02, 0);
        imem[11] = HALT_I;
        rst_off(1'b1, 0);
        wait_halt("t4", at);
        chk("t4_nfetch", fq.size(), 7);
        if (fq.size() == 7) begin
            chk("t4_f2", fq[2], 10);
            chk("t4_f3_taken", fq[3], 7);
            chk("t4_f5", fq[5], 10);
            chk("t4_f6_not_taken", fq[6], 11);
        end

        // T5: PC wrap both ways
        rst_on();
        imem[0]    = mk(1, 0, 2'b00, 0, 0, 0, 8'hFF, 0);
        imem[1023] = mk(1, 0, 2'b00, 0, 0, 0, 8'h02, 0);
        imem[1]    = HALT_I;
        rst_off(1'b1, 0);
        wait_halt("t5", at);
        chk("t5_nfetch", fq.size(), 3);
        if (fq.size() == 3) begin
            chk("t5_wrap_down", fq[1], 1023);
            chk("t5_wrap_up", fq[2], 1);
        end

        // T6: writes to R0 are discarded
        rst_on();
        imem[0] = mk(0, 0, 2'b01, 0, 0, 0, 8'h7F, 1);
        imem[1] = mk(0, 0, 2'b01, 0, 0, 0, 8'h7F, 0);
        imem[2] = mk(0, 0, 2'b11, 0, 0, 0, 8'h00, 1);
        imem[3] = HALT_I;
        rst_off(1'b1, 0);
        wait_halt("t6", at);
        chk("t6_out_r0sum", out_o, 32'd0);

        // T7: async reset while stalled on input, then a fresh run
        rst_on();
        imem[0] = mk(0, 0, 2'b01, 0, 0, 0, 8'h80, 1);
        imem[1] = mk(0, 0, 2'b10, 5'h1F, 0, 0, 8'h00, 2);
        rst_off(1'b1, 0);
        repeat (6) @(posedge clk_i);
        #3;
        chk("t7_pre_out", out_o, 32'hFFFF_FF80);
        chk("t7_pre_op", alu_op_o, 5'h1F);
        reset_i = 1'b1;
        #1;
        chk("t7_rst_out", out_o, 0);
        chk("t7_rst_op", alu_op_o, 0);
        chk("t7_rst_ready", in_ready_o, 0);
        chk("t7_rst_addr", imem_addr_o, 0);
`ifdef COBRA_RETIRE_CNT_EN
        chk("t7_rst_retired", retired_o, 0);
`endif
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        imem[0] = mk(0, 0, 2'b01, 0, 0, 0, 8'h05, 1);
        imem[1] = HALT_I;
        rst_off(1'b1, 0);
        wait_halt("t7", at);
        chk("t7_out", out_o, 32'd5);
`ifdef COBRA_RETIRE_CNT_EN
        chk("t7_retired", retired_o, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
